// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch resolution.
// Owns the architectural NZCV register, decides whether the EX instruction
// is a taken branch, and issues a registered one-cycle PC redirect plus
// flush toward IF/ID. Also keeps resolved-branch and taken-branch counters.
// The cycle after a redirect is a shadow cycle: the EX instruction there is
// wrong-path and is ignored entirely.
module branch_resolve #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic                  ex_stall,
   input  logic [2:0]            BranchOp,
   input  logic                  SregUp,
   input  logic [3:0]            cond,
   input  logic                  alu_n,
   input  logic                  alu_z,
   input  logic                  alu_c,
   input  logic                  alu_v,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic [DATA_WIDTH-1:0] pc_target,
   output logic                  redirect,
   output logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  flush,
   output logic [3:0]            nzcv,
   output logic [CNT_WIDTH-1:0]  br_count,
   output logic [CNT_WIDTH-1:0]  taken_count
);

   // Branch op encodings shared with the control path.
   localparam logic [2:0] BCOND_OP_NONE   = 3'd0;
   localparam logic [2:0] BCOND_OP_ZERO   = 3'd1;
   localparam logic [2:0] BCOND_OP_NZERO  = 3'd2;
   localparam logic [2:0] BCOND_OP_BRANCH = 3'd3;
   localparam logic [2:0] BCOND_OP_ALU    = 3'd4;
   localparam logic [2:0] BCOND_OP_COND   = 3'd5;

   // Evaluate a B.cond condition field against a {N,Z,C,V} flag set.
   function automatic logic condHolds(input logic [3:0] cc, input logic [3:0] flags);
      logic fN, fZ, fC, fV;
      logic res;
      fN = flags[3];
      fZ = flags[2];
      fC = flags[1];
      fV = flags[0];
      case (cc)
         4'h0:    res = fZ;
         4'h1:    res = ~fZ;
         4'h2:    res = fC;
         4'h3:    res = ~fC;
         4'h4:    res = fN;
         4'h5:    res = ~fN;
         4'h6:    res = fV;
         4'h7:    res = ~fV;
         4'h8:    res = fC & ~fZ;
         4'h9:    res = ~(fC & ~fZ);
         4'hA:    res = (fN == fV);
         4'hB:    res = (fN != fV);
         4'hC:    res = ~fZ & (fN == fV);
         4'hD:    res = ~(~fZ & (fN == fV));
         4'hE:    res = 1'b1;
         4'hF:    res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   logic                  redirect_r;
   logic                  flush_r;
   logic [DATA_WIDTH-1:0] redirectPc_r;
   logic [3:0]            nzcv_r;
   logic [CNT_WIDTH-1:0]  brCount_r;
   logic [CNT_WIDTH-1:0]  takenCount_r;

   logic                  accept_s;
   logic                  taken_s;
   logic                  fire_s;

   // Instruction acceptance: real, not frozen, and not in the redirect shadow.
   always_comb begin
      accept_s = ex_valid & ~ex_stall & ~redirect_r;
      fire_s   = accept_s & taken_s;
   end

   // Branch outcome from the op, the ALU zero flag and the registered NZCV.
   always_comb begin
      taken_s = 1'b0;
      case (BranchOp)
         BCOND_OP_NONE:   taken_s = 1'b0;
         BCOND_OP_ZERO:   taken_s = alu_z;
         BCOND_OP_NZERO:  taken_s = ~alu_z;
         BCOND_OP_BRANCH: taken_s = 1'b1;
         BCOND_OP_ALU:    taken_s = 1'b1;
         BCOND_OP_COND:   taken_s = condHolds(cond, nzcv_r);
         default:         taken_s = 1'b0;
      endcase
   end

   // Redirect/flush pulses, redirect target, NZCV and performance counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_r   <= 1'b0;
         flush_r      <= 1'b0;
         redirectPc_r <= {DATA_WIDTH{1'b0}};
         nzcv_r       <= 4'b0000;
         brCount_r    <= {CNT_WIDTH{1'b0}};
         takenCount_r <= {CNT_WIDTH{1'b0}};
      end else begin
         redirect_r <= fire_s;
         flush_r    <= fire_s;
         if (accept_s & SregUp) begin
            nzcv_r <= {alu_n, alu_z, alu_c, alu_v};
         end
         if (fire_s) begin
            redirectPc_r <= (BranchOp == BCOND_OP_ALU) ? alu_result : pc_target;
            takenCount_r <= takenCount_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
         if (accept_s & (BranchOp != BCOND_OP_NONE)) begin
            brCount_r <= brCount_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   assign redirect    = redirect_r;
   assign flush       = flush_r;
   assign redirect_pc = redirectPc_r;
   assign nzcv        = nzcv_r;
   assign br_count    = brCount_r;
   assign taken_count = takenCount_r;

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed stimulus with a reference model feeding an
// expected-result queue; every cycle's outputs are popped and compared.
module tb_branch_resolve;

   localparam int DW = 64;
   localparam int CW = 4;

   localparam logic [2:0] OP_NONE   = 3'd0;
   localparam logic [2:0] OP_ZERO   = 3'd1;
   localparam logic [2:0] OP_NZERO  = 3'd2;
   localparam logic [2:0] OP_BRANCH = 3'd3;
   localparam logic [2:0] OP_ALU    = 3'd4;
   localparam logic [2:0] OP_COND   = 3'd5;

   logic          clk = 1'b0;
   logic          rst;
   logic          exValid;
   logic          exStall;
   logic [2:0]    branchOp;
   logic          sregUp;
   logic [3:0]    condF;
   logic          aluN, aluZ, aluC, aluV;
   logic [DW-1:0] aluResult;
   logic [DW-1:0] pcTarget;
   logic          redirect;
   logic [DW-1:0] redirectPc;
   logic          flush;
   logic [3:0]    nzcv;
   logic [CW-1:0] brCount;
   logic [CW-1:0] takenCount;

   int asserts  = 0;
   int failures = 0;

   typedef struct packed {
      logic          redirect;
      logic          flush;
      logic [DW-1:0] pc;
      logic [3:0]    nzcv;
      logic [CW-1:0] br;
      logic [CW-1:0] tk;
   } exp_t;

   exp_t expQ[$];

   // reference model state
   logic          mRedir;
   logic [DW-1:0] mPc;
   logic [3:0]    mNzcv;
   logic [CW-1:0] mBr;
   logic [CW-1:0] mTk;

   branch_resolve #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .ex_valid    (exValid),
      .ex_stall    (exStall),
      .BranchOp    (branchOp),
      .SregUp      (sregUp),
      .cond        (condF),
      .alu_n       (aluN),
      .alu_z       (aluZ),
      .alu_c       (aluC),
      .alu_v       (aluV),
      .alu_result  (aluResult),
      .pc_target   (pcTarget),
      .redirect    (redirect),
      .redirect_pc (redirectPc),
      .flush       (flush),
      .nzcv        (nzcv),
      .br_count    (brCount),
      .taken_count (takenCount)
   );

   always #5 clk = ~clk;

   // Condition as ARM pairs: even code = base test, odd code = its inverse; NV taken.
   function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy && !z;
         3'd5:    base = (n == v);
         3'd6:    base = (n == v) && !z;
         3'd7:    base = 1'b1;
         default: base = 1'b0;
      endcase
      if (c == 4'hF) return 1'b1;
      return c[0] ? !base : base;
   endfunction

   function automatic logic refTaken(input logic [2:0] op, input logic [3:0] c,
                                     input logic z, input logic [3:0] f);
      case (op)
         OP_ZERO:   return z;
         OP_NZERO:  return !z;
         OP_BRANCH: return 1'b1;
         OP_ALU:    return 1'b1;
         OP_COND:   return refCond(c, f);
         default:   return 1'b0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      asserts++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idleInputs();
      rst = 1'b0; exValid = 1'b0; exStall = 1'b0; branchOp = OP_NONE; sregUp = 1'b0;
      condF = 4'h0; aluN = 1'b0; aluZ = 1'b0; aluC = 1'b0; aluV = 1'b0;
      aluResult = '0; pcTarget = '0;
   endtask

   // One clock: model predicts, pushes, edge, then pop and compare all outputs.
   task automatic cycle();
      exp_t e;
      logic acc, tk;
      acc = exValid && !exStall && !mRedir;
      tk  = refTaken(branchOp, condF, aluZ, mNzcv);
      if (rst) begin
         mRedir = 1'b0; mPc = '0; mNzcv = 4'b0000; mBr = '0; mTk = '0;
      end else begin
         if (acc && sregUp) mNzcv = {aluN, aluZ, aluC, aluV};
         if (acc && tk) mPc = (branchOp == OP_ALU) ? aluResult : pcTarget;
         if (acc && branchOp != OP_NONE) mBr = mBr + 1'b1;
         if (acc && tk) mTk = mTk + 1'b1;
         mRedir = acc && tk;
      end
      e.redirect = mRedir; e.flush = mRedir; e.pc = mPc;
      e.nzcv = mNzcv; e.br = mBr; e.tk = mTk;
      expQ.push_back(e);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      check("redirect", DW'(redirect), DW'(e.redirect));
      check("flush", DW'(flush), DW'(e.flush));
      check("redirect_pc", redirectPc, e.pc);
      check("nzcv", DW'(nzcv), DW'(e.nzcv));
      check("br_count", DW'(brCount), DW'(e.br));
      check("taken_count", DW'(takenCount), DW'(e.tk));
   endtask

   task automatic doReset();
      idleInputs(); rst = 1'b1; cycle(); rst = 1'b0;
   endtask

   task automatic doIdle();
      idleInputs(); cycle();
   endtask

   task automatic doSubs(input logic [3:0] f);
      idleInputs(); exValid = 1'b1; sregUp = 1'b1;
      {aluN, aluZ, aluC, aluV} = f;
      cycle();
   endtask

   task automatic doBranch(input logic [2:0] op, input logic [3:0] c, input logic z,
                           input logic [DW-1:0] alu, input logic [DW-1:0] tgt);
      idleInputs(); exValid = 1'b1; branchOp = op; condF = c; aluZ = z;
      aluResult = alu; pcTarget = tgt;
      cycle();
   endtask

   logic [3:0] pats [5];

   initial begin
      mRedir = 1'b0; mPc = '0; mNzcv = 4'b0000; mBr = '0; mTk = '0;
      idleInputs();
      pats[0] = 4'b0000; pats[1] = 4'b0100; pats[2] = 4'b1001;
      pats[3] = 4'b0010; pats[4] = 4'b1111;

      // reset state
      doReset();
      check("reset_redirect", DW'(redirect), '0);
      check("reset_br", DW'(brCount), '0);

      // SUBS then B.EQ
      doSubs(4'b0110);
      check("subs_nzcv", DW'(nzcv), DW'(4'b0110));
      doBranch(OP_COND, 4'h0, 1'b0, '0, 64'h100);
      check("beq_redirect", DW'(redirect), 64'd1);
      check("beq_flush", DW'(flush), 64'd1);
      check("beq_pc", redirectPc, 64'h100);
      check("beq_br", DW'(brCount), 64'd1);
      check("beq_tk", DW'(takenCount), 64'd1);
      doIdle();

      // CBZ not taken, CBNZ taken
      doReset();
      doBranch(OP_ZERO, 4'h0, 1'b0, '0, 64'h80);
      check("cbz_redirect", DW'(redirect), 64'd0);
      doBranch(OP_NZERO, 4'h0, 1'b0, '0, 64'h40);
      check("cbnz_redirect", DW'(redirect), 64'd1);
      check("cbnz_pc", redirectPc, 64'h40);
      check("cbnz_br", DW'(brCount), 64'd2);
      check("cbnz_tk", DW'(takenCount), 64'd1);
      doIdle();

      // BR followed by a shadow CMP
      doBranch(OP_ALU, 4'h0, 1'b0, 64'hDEAD_BEE0, 64'h200);
      check("br_pc", redirectPc, 64'hDEAD_BEE0);
      check("br_redirect", DW'(redirect), 64'd1);
      idleInputs(); exValid = 1'b1; sregUp = 1'b1; aluZ = 1'b1; cycle();
      check("shadow_redirect", DW'(redirect), 64'd0);
      check("shadow_nzcv", DW'(nzcv), DW'(4'b0000));
      doIdle();

      // condition sweep
      for (int p = 0; p < 5; p++) begin
         doSubs(pats[p]);
         for (int c = 0; c < 16; c++) begin
            doBranch(OP_COND, 4'(c), 1'b0, '0, 64'h1000 + 64'(c));
            if (c >= 14) check("al_nv_taken", DW'(redirect), 64'd1);
            doIdle();
         end
      end

      // stalled taken B
      doReset();
      idleInputs(); exValid = 1'b1; exStall = 1'b1; branchOp = OP_BRANCH; pcTarget = 64'h300;
      for (int s = 0; s < 3; s++) begin
         cycle();
         check("stall_no_redirect", DW'(redirect), 64'd0);
      end
      exStall = 1'b0;
      cycle();
      check("release_redirect", DW'(redirect), 64'd1);
      check("release_pc", redirectPc, 64'h300);
      check("release_br", DW'(brCount), 64'd1);
      doIdle();
      check("release_pulse_end", DW'(redirect), 64'd0);

      // counter wrap
      doReset();
      for (int k = 0; k < 16; k++) begin
         doBranch(OP_BRANCH, 4'h0, 1'b0, '0, 64'h400 + 64'(k * 4));
         doIdle();
      end
      check("wrap_br", DW'(brCount), 64'd0);
      check("wrap_tk", DW'(takenCount), 64'd0);

      // reset mid-sequence with a redirect pending
      doBranch(OP_BRANCH, 4'h0, 1'b0, '0, 64'h500);
      doIdle();
      doBranch(OP_BRANCH, 4'h0, 1'b0, '0, 64'h600);
      idleInputs(); rst = 1'b1; exValid = 1'b1; branchOp = OP_BRANCH; pcTarget = 64'h700;
      cycle();
      rst = 1'b0;
      check("rst_redirect", DW'(redirect), 64'd0);
      check("rst_flush", DW'(flush), 64'd0);
      check("rst_pc", redirectPc, 64'd0);
      check("rst_nzcv", DW'(nzcv), 64'd0);
      check("rst_br", DW'(brCount), 64'd0);
      check("rst_tk", DW'(takenCount), 64'd0);
      doIdle();

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- EX-stage consumer of the control path's `BranchOp` and `SregUp` outputs.
- Holds the architectural NZCV status register and evaluates CBZ/CBNZ/B/B.cond/BL/BR outcomes.
- Issues a registered PC redirect plus a pipeline flush toward IF/ID.
- Keeps branch/taken performance counters.

Parameters:
DATA_WIDTH, 64, width of PC, branch target and ALU result
CNT_WIDTH, 32, width of each performance counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ex_valid  input  1  EX stage holds a real instruction
ex_stall  input  1  EX stage frozen this cycle
BranchOp  input  3  branch op from control, `BCOND_OP_*` encodings of common.vh
SregUp  input  1  update NZCV from ALU flags
cond  input  4  B.cond condition field, instruction bits [3:0]
alu_n  input  1  ALU negative flag
alu_z  input  1  ALU zero flag
alu_c  input  1  ALU carry flag
alu_v  input  1  ALU overflow flag
alu_result  input  DATA_WIDTH  ALU output, the target for BR
pc_target  input  DATA_WIDTH  PC + sign-extended offset << 2
redirect  output  1  one-cycle pulse: fetch from redirect_pc
redirect_pc  output  DATA_WIDTH  next-PC when redirect=1
flush  output  1  squash IF/ID/EX wrong-path instructions
nzcv  output  4  status register {N,Z,C,V}
br_count  output  CNT_WIDTH  resolved branch instructions
taken_count  output  CNT_WIDTH  taken branches

Behaviour:
- Reset (clk edge with rst=1): redirect=0, redirect_pc=0, flush=0, nzcv=4'b0000, br_count=0, taken_count=0. A redirect pending when rst rises is dropped.
- shadow = redirect (registered). accept = ex_valid & ~ex_stall & ~shadow.
- In a shadow cycle the EX instruction is wrong-path: no NZCV update, no redirect, no counting.
- NZCV update: on accept & SregUp, nzcv <= {alu_n, alu_z, alu_c, alu_v} at the clock edge.
- taken is combinational from the inputs and the registered nzcv:
  - BCOND_OP_NONE: 0
  - BCOND_OP_ZERO: alu_z
  - BCOND_OP_NZERO: ~alu_z
  - BCOND_OP_BRANCH: 1
  - BCOND_OP_ALU: 1
  - BCOND_OP_COND: condition evaluated on the registered nzcv
  - Any undefined encoding: 0
- B.cond uses the flags as registered before the current edge. Same-cycle SregUp is not forwarded into its own condition.
- Condition table:
  - 0 EQ Z; 1 NE ~Z; 2 HS C; 3 LO ~C
  - 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V
  - 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V
  - C GT ~Z&(N==V); D LE ~(~Z&(N==V)); E AL 1; F NV 1
- Redirect latency is 1 cycle: redirect <= accept & taken; flush <= accept & taken.
  - Both are single-cycle pulses, independent of ex_stall in the pulse cycle.
- redirect_pc <= alu_result for BCOND_OP_ALU, else pc_target. Loaded only when accept & taken; otherwise it holds its value.
- Back-to-back taken branches: the second is in shadow, so it is ignored. The redirect never stays high for 2 consecutive cycles.
- Counters:
  - br_count += 1 on accept & BranchOp != NONE.
  - taken_count += 1 on accept & taken.
  - Both wrap modulo 2^CNT_WIDTH, with no saturation.
- ex_stall=1 or ex_valid=0: no state change except clearing redirect/flush.
- The block has no combinational path from inputs to outputs.

Test Plan:
- Reset, then SUBS (SregUp=1, n=0 z=1 c=1 v=0), then B.cond cond=0 (EQ), pc_target=0x100 -> nzcv=4'b0110 one edge after SUBS; redirect=1, flush=1, redirect_pc=0x100 one cycle after the B.cond; br_count=1, taken_count=1.
- CBZ with alu_z=0, then CBNZ with alu_z=0 and pc_target=0x40 -> no redirect for CBZ; redirect_pc=0x40 for CBNZ; br_count=2, taken_count=1.
- BR with alu_result=0xDEAD_BEE0 followed by a valid CMP (SregUp=1, z=1) in the shadow cycle -> redirect_pc=0xDEADBEE0, redirect high for exactly 1 cycle; nzcv unchanged by the shadow CMP.
- Sweep all 16 cond values against the nzcv patterns 0000, 0100, 1001, 0010, 1111 -> taken matches the condition table; AL and NV always taken.
- Taken B held with ex_stall=1 for 3 cycles, then released -> no redirect while stalled; one redirect pulse the cycle after release; counters +1 each.
- Set the counters near wrap (CNT_WIDTH=4), issue 16 taken B's spaced 2 cycles apart -> both counters wrap to 0; assert rst mid-sequence -> all outputs 0 on the next cycle.
